button_debounce: RTL and testbench
==================================

// Module: button_debounce
// PURPOSE
//  Input-side counterpart of the LED blink path: samples NBTN raw push-button pins
//  (async, bouncy) on the HX8K board clock and produces clean levels plus one-cycle
//  press/release strobes for downstream logic.
//  Each channel has a 2-FF synchronizer and a stability counter. LEVEL follows the
//  pin only after the pin holds a new value for 2^CNT_WIDTH consecutive cycles.
// PARAMETERS
//  NBTN       4   number of independent button channels
//  CNT_WIDTH  18  stability counter width; window = 2^CNT_WIDTH cycles (~21.8 ms @ 12 MHz)
// PORTS
//  CLKIN   in   1     board clock; all state on rising edge
//  RESETN  in   1     asynchronous active-low reset
//  BTN     in   NBTN  raw button pins, asynchronous to CLKIN, active-high
//  LEVEL   out  NBTN  debounced level per channel
//  RISE    out  NBTN  1-cycle strobe, coincident with LEVEL 0->1
//  FALL    out  NBTN  1-cycle strobe, coincident with LEVEL 1->0
// BEHAVIOUR
//  - Reset (RESETN=0, async): sync FFs, counters, LEVEL, RISE and FALL all clear to 0.
//    No strobe is emitted on reset release, even if BTN is already high.
//  - Sync: s1<=BTN[i]; s2<=s1. Only s2 feeds channel logic. Nothing else reads BTN.
//  - Per channel, per edge, priority as listed:
//    1. s2==LEVEL: cnt<=0; no strobe.
//    2. s2!=LEVEL, cnt!=MAX (MAX=2^CNT_WIDTH-1): cnt<=cnt+1.
//    3. s2!=LEVEL, cnt==MAX: LEVEL<=s2; cnt<=0; RISE<=s2 / FALL<=~s2 for that edge only.
//  - RISE/FALL are registered, high exactly one cycle, never both high on one channel.
//    LEVEL and strobes change on the same edge.
//  - Latency: the new pin value is first captured into s1 at edge E0. LEVEL and the
//    strobe update at edge E0+2^CNT_WIDTH+1, provided s2 held the new value throughout.
//  - Glitch rejection: if s2 returns to LEVEL for a single cycle, cnt restarts from 0.
//    A pulse shorter than 2^CNT_WIDTH cycles never reaches LEVEL.
//  - Counter never wraps: MAX is only reached in case 3, which clears cnt.
//  - Channels are fully independent. Simultaneous transitions on several channels
//    give simultaneous strobes.
//  - Reset mid-count: count is discarded. Counting restarts from 0 after RESETN
//    deasserts, with the 2-cycle sync refill.
//  - Fabric-only design: no SB_IO registers.
// STRUCTURE
//  - No shared package needed. CNT_WIDTH default lives in the board constants file
//    next to the clock frequency.
//  - One sub-module: debounce_chan (1-bit sync + counter + LEVEL/RISE/FALL regs).
//    button_debounce is a generate loop of NBTN instances.
//  - Counter increment uses plain fabric add; carry out is unused.
// TESTING (bench uses CNT_WIDTH=4 -> 16-cycle window, NBTN=4)
//  1. Reset: RESETN=0 with BTN=4'hF, release -> LEVEL=0, RISE=0, FALL=0 for the first
//     2 cycles; the 0->1 transitions are then debounced normally.
//  2. Clean press: BTN[0] 0->1 captured at E0, held -> LEVEL[0]=1 and RISE[0]=1 at
//     E0+17; RISE[0]=0 at E0+18; FALL=0 throughout.
//  3. Bounce: BTN[1] high 10 cycles, low 1 cycle, high 20 cycles -> LEVEL[1] rises
//     16+1 edges after the final 0->1 capture; exactly one RISE[1] pulse.
//  4. Short glitch: BTN[2] high for 15 cycles then low -> LEVEL[2] stays 0; no RISE/FALL.
//  5. Release and concurrency: BTN[0] and BTN[3] change on the same edge, both held ->
//     FALL[0] and RISE[3] asserted on the same edge, each for 1 cycle.
//  6. Reset mid-count: BTN[0] held high 10 cycles, RESETN pulsed low -> after release,
//     LEVEL[0] rises 17 edges after the first post-reset capture edge, not earlier.

Source files
------------

// File: rtl/button_debounce_pkg.sv
// Board-level constants shared by the push-button input path.
package button_debounce_pkg;

  // 2^18 cycles at the 12 MHz HX8K board clock is a debounce window of about 21.8 ms.
  localparam int unsigned DebounceCntWidth = 18;

  // Button pins brought out on the board.
  localparam int unsigned NumButtons = 4;

endpackage : button_debounce_pkg

// File: rtl/debounce_chan.sv
// One debounced button channel: 2-FF synchronizer, stability counter, level and strobes.
module debounce_chan
  import button_debounce_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = DebounceCntWidth
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam logic [CNT_WIDTH-1:0] CntMax = '1;

  logic                 s1_q, s2_q;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 level_q, level_d;
  logic                 rise_q, rise_d;
  logic                 fall_q, fall_d;

  // Synchronize the asynchronous pin; only s2_q is used by the channel logic.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= btn_i;
      s2_q <= s1_q;
    end
  end

  // Count consecutive cycles the synchronized pin disagrees with the level; accept at MAX.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (s2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q != CntMax) begin
      // Carry out is dropped; MAX is handled by the branch below so it never wraps.
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end else begin
      level_d = s2_q;
      cnt_d   = '0;
      rise_d  = s2_q;
      fall_d  = ~s2_q;
    end
  end

  // Counter, level and strobe registers; strobes update on the same edge as the level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule : debounce_chan

// File: rtl/button_debounce.sv
// Debounces NBTN raw push-button pins into clean levels and one-cycle press/release strobes.
module button_debounce
  import button_debounce_pkg::*;
#(
  parameter int unsigned NBTN      = NumButtons,
  parameter int unsigned CNT_WIDTH = DebounceCntWidth
) (
  input  logic            CLKIN,
  input  logic            RESETN,
  input  logic [NBTN-1:0] BTN,
  output logic [NBTN-1:0] LEVEL,
  output logic [NBTN-1:0] RISE,
  output logic [NBTN-1:0] FALL
);

  // Channels are fully independent; one instance per pin.
  for (genvar i = 0; i < NBTN; i++) begin : g_chan
    debounce_chan #(
      .CNT_WIDTH(CNT_WIDTH)
    ) u_chan (
      .clk_i  (CLKIN),
      .rst_ni (RESETN),
      .btn_i  (BTN[i]),
      .level_o(LEVEL[i]),
      .rise_o (RISE[i]),
      .fall_o (FALL[i])
    );
  end

endmodule : button_debounce

// File: tb/tb_button_debounce.sv
// Scoreboard bench for button_debounce with a window-based reference model.
module tb_button_debounce;

  localparam int unsigned NBTN = 4;
  localparam int unsigned CW   = 4;
  localparam int          WIN  = 16;

  logic            CLKIN  = 1'b0;
  logic            RESETN = 1'b0;
  logic [NBTN-1:0] BTN    = '0;
  logic [NBTN-1:0] LEVEL, RISE, FALL;

  button_debounce #(
    .NBTN     (NBTN),
    .CNT_WIDTH(CW)
  ) dut (
    .CLKIN (CLKIN),
    .RESETN(RESETN),
    .BTN   (BTN),
    .LEVEL (LEVEL),
    .RISE  (RISE),
    .FALL  (FALL)
  );

  always #5 CLKIN = ~CLKIN;

  typedef struct packed {
    logic [NBTN-1:0] lvl;
    logic [NBTN-1:0] rise;
    logic [NBTN-1:0] fall;
  } exp_t;

  exp_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model: pin_at[e] is the pin value present at post-reset edge e (index 0 unused).
  // The channel logic sees that value two edges later. A level flips at edge k when the
  // delayed pin has shown the opposite value on each of the last WIN edges, all of them
  // after the previous flip (or after reset).
  logic [NBTN-1:0] pin_at[$];
  int              edge_n;
  logic [NBTN-1:0] m_level;
  int              last_chg[NBTN];

  function automatic logic [NBTN-1:0] seen_at(int k);
    if (k >= 3) return pin_at[k-2];
    return '0;
  endfunction

  task automatic model_reset();
    pin_at.delete();
    pin_at.push_back('0);
    edge_n  = 0;
    m_level = '0;
    for (int i = 0; i < NBTN; i++) last_chg[i] = 0;
  endtask

  task automatic model_step(input logic [NBTN-1:0] b);
    exp_t            e;
    logic [NBTN-1:0] v;
    bit              stable;
    e = '0;
    edge_n++;
    pin_at.push_back(b);
    for (int i = 0; i < NBTN; i++) begin
      if (edge_n - last_chg[i] >= WIN) begin
        stable = 1'b1;
        for (int j = edge_n - WIN + 1; j <= edge_n; j++) begin
          v = seen_at(j);
          if (v[i] == m_level[i]) stable = 1'b0;
        end
        if (stable) begin
          m_level[i]  = ~m_level[i];
          last_chg[i] = edge_n;
          if (m_level[i]) e.rise[i] = 1'b1;
          else            e.fall[i] = 1'b1;
        end
      end
    end
    e.lvl = m_level;
    sb_q.push_back(e);
  endtask

  task automatic tick(input logic [NBTN-1:0] b);
    BTN = b;
    @(posedge CLKIN);
    model_step(b);
    #1;
  endtask

  task automatic hold(input logic [NBTN-1:0] b, input int n);
    repeat (n) tick(b);
  endtask

  // Assert reset for n edges with BTN=b; outputs must read zero throughout.
  task automatic hold_reset(input int n, input logic [NBTN-1:0] b);
    @(negedge CLKIN);
    #1;
    RESETN = 1'b0;
    model_reset();
    repeat (n) begin
      BTN = b;
      @(posedge CLKIN);
      sb_q.push_back('0);
      #1;
    end
    RESETN = 1'b1;
    model_reset();
  endtask

  // Monitor: outputs are presented every cycle; compare away from the active edge.
  exp_t got, want;
  always @(negedge CLKIN) begin
    if ((RISE & FALL) != '0) begin
      miscompares++;
      $display("FAIL rise_fall_overlap t=%0t R=%b F=%b", $time, RISE, FALL);
    end
    if (sb_q.size() > 0) begin
      want = sb_q.pop_front();
      got  = {LEVEL, RISE, FALL};
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL lvl_rise_fall t=%0t got L=%b R=%b F=%b expected L=%b R=%b F=%b",
                 $time, got.lvl, got.rise, got.fall, want.lvl, want.rise, want.fall);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int              run_len[NBTN];
  logic [NBTN-1:0] p;

  initial begin
    model_reset();
    // Reset with all pins high, then debounce all four rising.
    hold_reset(3, 4'hF);
    hold(4'hF, 25);
    hold(4'h0, 25);
    // Clean press on channel 0.
    hold(4'b0001, 25);
    // Bounce on channel 1.
    hold(4'b0011, 10);
    hold(4'b0001, 1);
    hold(4'b0011, 20);
    hold(4'b0011, 5);
    // 15-cycle glitch on channel 2 never reaches LEVEL.
    hold(4'b0111, 15);
    hold(4'b0011, 20);
    // Channel 0 release and channel 3 press on the same edge.
    hold(4'b1010, 25);
    // Reset mid-count on channel 0.
    hold(4'b1011, 10);
    hold_reset(2, 4'b1011);
    hold(4'b1011, 25);
    // Randomized bouncing with run lengths straddling the window.
    p = 4'b1011;
    for (int i = 0; i < NBTN; i++) run_len[i] = $urandom_range(1, 40);
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < NBTN; i++) begin
        if (run_len[i] == 0) begin
          p[i]       = ~p[i];
          run_len[i] = $urandom_range(1, 40);
        end else begin
          run_len[i]--;
        end
      end
      if (c == 1000) hold_reset(3, p);
      tick(p);
    end
    hold(p, 30);
    @(negedge CLKIN);
    #1;
    if (vectors < 100) begin
      $display("FAIL vector_count: only %0d vectors checked", vectors);
    end
    if (miscompares != 0) begin
      $display("FAIL summary: %0d miscompares", miscompares);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_button_debounce
